// File: rtl/vector_alu_pkg.sv
// Shared opcode encoding, default geometry and lane-vector type for the vector ALU sequencer.
package vector_alu_pkg;

  localparam int WIDTH_DEF        = 24;
  localparam int VECTOR_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ADD   = 3'b000,
    SUB   = 3'b001,
    MULT  = 3'b010,
    AND   = 3'b011,
    CMP   = 3'b100,
    SHL   = 3'b101,
    PASSA = 3'b110,
    PASSB = 3'b111
  } opcode_t;

  typedef logic [VECTOR_WIDTH_DEF-1:0][WIDTH_DEF-1:0] laneVec_t;

endpackage

// File: rtl/vector_flag_gen.sv
// Zero / negative status for a lane vector: zero when every lane is 0, neg from lane 0 MSB.
module vector_flag_gen #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8
) (
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] lanes,
  output logic                               zero,
  output logic                               neg
);

  assign zero = (lanes == '0);
  assign neg  = lanes[0][WIDTH-1];

endmodule

// File: rtl/vector_alu_sequencer.sv
// Request/response sequencer around a combinational vector ALU (IDLE -> DRIVE -> RESP).
// Optional per-lane masking is enabled with the VSEQ_MASK_EN macro.
module vector_alu_sequencer
  import vector_alu_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [2:0]                          req_op,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  req_a,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  req_b,
`ifdef VSEQ_MASK_EN
  input  logic [VECTOR_WIDTH-1:0]             req_mask,
`endif
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  alu_a,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  alu_b,
  output logic [2:0]                          alu_sel,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  alu_out,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  rsp_data,
  output logic                                rsp_zero,
  output logic                                rsp_neg,
  output logic                                busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]                         state;
  logic                               accept;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] mergedData_p1;
  logic                               mergedZero_p1;
  logic                               mergedNeg_p1;

  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef VSEQ_MASK_EN
  logic [VECTOR_WIDTH-1:0] mask_p0;

  // Masked-off lanes keep operand A instead of the ALU result.
  always_comb begin
    mergedData_p1 = alu_out;
    for (int i = 0; i < VECTOR_WIDTH; i++)
      if (!mask_p0[i]) mergedData_p1[i] = alu_a[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      mask_p0 <= '1;
    else if (accept) mask_p0 <= req_mask;
  end
`else
  assign mergedData_p1 = alu_out;
`endif

  vector_flag_gen #(
    .WIDTH        (WIDTH),
    .VECTOR_WIDTH (VECTOR_WIDTH)
  ) u_flagGen (
    .lanes (mergedData_p1),
    .zero  (mergedZero_p1),
    .neg   (mergedNeg_p1)
  );

  // Stage p0: operands into the ALU on accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= 3'b000;
    end else if (accept) begin
      alu_a   <= req_a;
      alu_b   <= req_b;
      alu_sel <= req_op;
    end
  end

  // Stage p1: capture ALU result at the end of DRIVE, hold through RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (accept) state <= DRIVE;
        DRIVE: begin
          rsp_data <= mergedData_p1;
          rsp_zero <= mergedZero_p1;
          rsp_neg  <= mergedNeg_p1;
          state    <= RESP;
        end
        RESP:    if (rsp_ready) state <= accept ? DRIVE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vector_alu_sequencer.md
VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the element width in bits.
REQ-002 The block SHALL have parameter VECTOR_WIDTH, default 8, giving the number of lanes.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_op  in  3  ALU select code
- req_a  in  VECTOR_WIDTH x WIDTH  operand A
- req_b  in  VECTOR_WIDTH x WIDTH  operand B
- req_mask  in  VECTOR_WIDTH  lane enable; present only with VSEQ_MASK_EN
- alu_a  out  VECTOR_WIDTH x WIDTH  registered operand A to the vector ALU
- alu_b  out  VECTOR_WIDTH x WIDTH  registered operand B to the vector ALU
- alu_sel  out  3  registered select to the vector ALU
- alu_out  in  VECTOR_WIDTH x WIDTH  combinational ALU result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  VECTOR_WIDTH x WIDTH  captured result
- rsp_zero  out  1  all lanes of rsp_data equal zero
- rsp_neg  out  1  MSB of lane 0 of rsp_data
- busy  out  1  state is not IDLE

Function
REQ-005 The block SHALL implement the FSM states IDLE, DRIVE and RESP.
REQ-006 In IDLE, req_ready SHALL be 1; on req_valid&&req_ready the block SHALL register req_a, req_b and req_op into alu_a, alu_b and alu_sel, then enter DRIVE.
REQ-007 DRIVE SHALL last exactly one cycle; at its closing edge alu_out SHALL be captured into rsp_data, rsp_zero and rsp_neg SHALL be computed from the captured value, and the FSM SHALL enter RESP.
REQ-008 rsp_valid SHALL be 1 only in RESP; the latency from the accept edge to rsp_valid rising SHALL be 1 cycle.
REQ-009 In RESP, rsp_data, rsp_zero and rsp_neg SHALL hold stable until rsp_valid&&rsp_ready.
REQ-010 req_ready SHALL equal (state==IDLE) || (state==RESP && rsp_ready); it SHALL be 0 in DRIVE.
REQ-011 When a response handshake and a request handshake fall on the same edge, the block SHALL retire the response and load the new request, going directly RESP->DRIVE, for one operation per 2 cycles.
REQ-012 On a response handshake with no new request, the FSM SHALL return to IDLE.
REQ-013 alu_a, alu_b and alu_sel SHALL change only on an accept edge and SHALL hold their values otherwise.
REQ-014 The block SHALL pass opcodes through unmodified, including 3'b101 (lane-0 shift broadcast), 3'b110 (pass A) and 3'b111 (pass B).

Reset
REQ-015 When rst_n is low at a clock edge, the FSM SHALL go to IDLE and alu_a, alu_b and rsp_data SHALL be set to 0.
REQ-016 On that reset edge, alu_sel SHALL be set to 3'b000 and rsp_valid, rsp_zero, rsp_neg and busy SHALL be set to 0.
REQ-017 Reset during DRIVE or RESP SHALL discard the operation in flight with no response.
REQ-018 req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-019 With VSEQ_MASK_EN defined, req_mask SHALL be registered at accept.
REQ-020 With VSEQ_MASK_EN defined, each lane whose mask bit is 0 SHALL capture that lane of alu_a into rsp_data instead of alu_out, and rsp_zero and rsp_neg SHALL use the merged data.
REQ-021 Without VSEQ_MASK_EN, the req_mask port SHALL be absent and all lanes SHALL capture alu_out.

Structure
REQ-022 Package vector_alu_pkg SHALL hold the opcode enum (ADD=000, SUB=001, MULT=010, AND=011, CMP=100, SHL=101, PASSA=110, PASSB=111), the default WIDTH and VECTOR_WIDTH, and the lane-vector typedef.
REQ-023 Sub-module vector_flag_gen SHALL compute rsp_zero and rsp_neg from a lane vector.

Verification
REQ-024 Reset, then req_op=ADD, a lane i = i, b lane i = 1 -> rsp_valid rises 1 cycle after accept with lane i = i+1 and rsp_zero=0.
REQ-025 SUB with a = b = 24'h000005 in all lanes -> rsp_data all 0 and rsp_zero=1.
REQ-026 SUB with a lane 0 = 1 and b lane 0 = 2 -> rsp_neg=1 (lane 0 = 24'hFFFFFF).
REQ-027 rsp_ready held low for 5 cycles -> rsp_data stable, req_ready=0; raise rsp_ready together with req_valid -> back-to-back accept, next rsp_valid 1 cycle later.
REQ-028 rst_n low during DRIVE -> no rsp_valid and all outputs 0 on the next cycle.
REQ-029 With VSEQ_MASK_EN, mask 8'b0000_1111 and op ADD -> lanes 4-7 equal req_a and lanes 0-3 equal the sum.
